// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexes one BCD decoder over DIGITS positions, blanking between slots, loading new values only at frame boundaries.
// Define SEG_SCAN_LZ_BLANK_EN to suppress leading zeros (digit 0 always shown).
module seg_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int BLANK  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_bcd,
  output logic [3:0]            bcd_out,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_start
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [4*DIGITS-1:0]  disp_q, disp_d;
  logic [4*DIGITS-1:0]  pend_q, pend_d;
  logic                 pend_vld_q, pend_vld_d;
  logic                 load_ready_q, load_ready_d;
  logic [3:0]           bcd_q, bcd_d;
  logic                 lit_q, lit_d;

  logic                 wrap, boundary, accept;
  logic [3:0]           sel_nib;
  logic                 sel_lit;
`ifdef SEG_SCAN_LZ_BLANK_EN
  logic                 zero_from_k;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      load_ready_q <= 1'b1;
      bcd_q        <= 4'd0;
      lit_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      load_ready_q <= load_ready_d;
      bcd_q        <= bcd_d;
      lit_q        <= lit_d;
    end
  end

  always_comb begin
    wrap     = (cnt_q == CNT_MAX);
    boundary = wrap && (idx_q == IDX_MAX);
    accept   = load_valid && load_ready_q;
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (wrap) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
  end

  always_comb begin
    state_d = (cnt_d >= CNT_BLANK) ? ST_SHOW : ST_BLANK;
  end

  always_comb begin
    disp_d     = (boundary && pend_vld_q) ? pend_q : disp_q;
    pend_d     = accept ? load_bcd : pend_q;
    pend_vld_d = accept || (pend_vld_q && !boundary);
    // Ready drops right after a transfer but only recovers one cycle after the flag clears.
    load_ready_d = !(pend_vld_q || accept);

    sel_nib = 4'd0;
    sel_lit = 1'b0;
`ifdef SEG_SCAN_LZ_BLANK_EN
    zero_from_k = 1'b1;
`endif
    for (int k = DIGITS - 1; k >= 0; k--) begin
`ifdef SEG_SCAN_LZ_BLANK_EN
      zero_from_k = zero_from_k && (disp_d[4*k +: 4] == 4'd0);
      if (idx_d == IW'(k)) begin
        sel_nib = disp_d[4*k +: 4];
        sel_lit = (disp_d[4*k +: 4] <= 4'd9) && !(zero_from_k && (k != 0));
      end
`else
      if (idx_d == IW'(k)) begin
        sel_nib = disp_d[4*k +: 4];
        sel_lit = (disp_d[4*k +: 4] <= 4'd9);
      end
`endif
    end

    bcd_d = wrap ? sel_nib : bcd_q;
    lit_d = wrap ? sel_lit : lit_q;
  end

  always_comb begin
    for (int k = 0; k < DIGITS; k++) begin
      digit_en[k] = (state_q == ST_SHOW) && lit_q && (idx_q == IW'(k));
    end
    bcd_out     = bcd_q;
    load_ready  = load_ready_q;
    frame_start = !reset && (cnt_q == '0) && (idx_q == '0);
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl at DIGITS=4, DIV=8, BLANK=2: frame-level reference model plus directed spot checks.
module tb_seg_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_bcd;
  logic [3:0]  bcd_out;
  logic [3:0]  digit_en;
  logic        frame_start;

  int vectors;
  int miscompares;

  int          t;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  logic        m_pflag;
  logic        m_ready;
  int          ret_t;

  seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_bcd    (load_bcd),
    .bcd_out     (bcd_out),
    .digit_en    (digit_en),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    t       = 0;
    m_disp  = 16'h0;
    m_pend  = 16'h0;
    m_pflag = 1'b0;
    m_ready = 1'b1;
    ret_t   = -1;
  endtask

  // Apply one cycle of inputs, compare against the model, then advance one clock.
  task automatic step(input logic rv, input logic lv, input logic [15:0] lb);
    int         pos, idx;
    logic [3:0] nib;
    logic       lit;
    logic [3:0] exp_en;
    logic [15:0] upper;
    logic       acc;
    reset = rv; load_valid = lv; load_bcd = lb;
    #1;
    pos   = t % DIV;
    idx   = (t / DIV) % DIGITS;
    upper = m_disp >> (4 * idx);
    nib   = upper[3:0];
    lit   = (nib <= 4'd9);
`ifdef SEG_SCAN_LZ_BLANK_EN
    if (idx != 0 && upper == 16'h0) lit = 1'b0;
`endif
    exp_en = (pos >= BLANK && lit) ? 4'(1 << idx) : 4'b0;
    check("digit_en",    32'(digit_en),    32'(exp_en));
    check("bcd_out",     32'(bcd_out),     32'(nib));
    check("frame_start", 32'(frame_start), 32'(!rv && (t % FRAME == 0)));
    check("load_ready",  32'(load_ready),  32'(m_ready));
    if (rv) begin
      model_reset();
    end else begin
      acc = lv && m_ready;
      if ((t % FRAME == FRAME - 1) && m_pflag) begin
        m_disp  = m_pend;
        m_pflag = 1'b0;
        ret_t   = t + 2;
      end
      if (acc) begin
        m_pend  = lb;
        m_pflag = 1'b1;
        m_ready = 1'b0;
      end
      t++;
      if (t == ret_t) m_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [15:0] rnd_val();
    logic [15:0] v;
    for (int k = 0; k < 4; k++) v[4*k +: 4] = 4'($urandom_range(0, 11));
    if ($urandom_range(0, 2) == 0) v = v >> (4 * $urandom_range(1, 3));
    return v;
  endfunction

  task automatic load_when_ready(input logic [15:0] v);
    for (int g = 0; g < 3 * FRAME && !m_ready; g++) step(1'b0, 1'b0, 16'h0);
    check("ready_wait", 32'(load_ready), 32'h1);
    step(1'b0, 1'b1, v);
    for (int c = 0; c < 3 * FRAME; c++) step(1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; load_valid = 1'b0; load_bcd = 16'h0;
    model_reset();
    @(negedge clk);
    repeat (2) step(1'b1, 1'b0, 16'h0);

    // First load at cycle 5, then a competing load held across cycles 6-40.
    for (int c = 0; c < 5; c++) begin
      if (c == 2) check("en_first_show", 32'(digit_en), 32'h1);
      if (c == 1) check("en_first_blank", 32'(digit_en), 32'h0);
      step(1'b0, 1'b0, 16'h0);
    end
    step(1'b0, 1'b1, 16'h1234);
    for (int c = 6; c <= 40; c++) begin
      if (c == 6)  check("ready_drop",   32'(load_ready), 32'h0);
      if (c == 31) check("old_disp_31",  32'(bcd_out),    32'h0);
      if (c == 32) check("new_disp_32",  32'(bcd_out),    32'h4);
      if (c == 32) check("ready_lag_32", 32'(load_ready), 32'h0);
      if (c == 33) check("ready_back",   32'(load_ready), 32'h1);
      if (c == 34) check("second_taken", 32'(load_ready), 32'h0);
      if (c == 40) check("digit1_40",    32'(bcd_out),    32'h3);
      step(1'b0, 1'b1, 16'h5678);
    end
    for (int c = 41; c <= 80; c++) begin
      if (c == 48) check("digit2_48",  32'(bcd_out), 32'h2);
      if (c == 56) check("digit3_56",  32'(bcd_out), 32'h1);
      if (c == 63) check("still1_63",  32'(bcd_out), 32'h1);
      if (c == 64) check("second_64",  32'(bcd_out), 32'h8);
      if (c == 64) check("frame_64",   32'(frame_start), 32'h1);
      step(1'b0, 1'b0, 16'h0);
    end

    // Randomised loads including invalid nibbles and leading zeros.
    for (int c = 0; c < 800; c++) step(1'b0, ($urandom_range(0, 2) == 0), rnd_val());

    load_when_ready(16'h9A05);
    load_when_ready(16'h0040);
    load_when_ready(16'h0000);

    // Reset pulse at cycle 19 while a value is pending.
    step(1'b1, 1'b0, 16'h0);
    for (int c = 0; c < 19; c++) step(1'b0, (c == 3), 16'h4321);
    step(1'b1, 1'b0, 16'h0);
    for (int c = 0; c < 70; c++) begin
      if (c == 0) check("rst_en",    32'(digit_en),   32'h0);
      if (c == 0) check("rst_ready", 32'(load_ready), 32'h1);
      if (c == 32) check("pend_dropped", 32'(bcd_out), 32'h0);
      step(1'b0, 1'b0, 16'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
